// File: rtl/hack_mem_arbiter.sv
// Purpose: share one single-port data RAM between the Hack CPU (port 0) and a DMA mover (port 1).
// Latency: grant, RAM command and cpu_stall are combinational; read data returns one cycle after grant.
// Backpressure: CPU wins contention; after STARVE_LIMIT denied DMA cycles the DMA is forced through.
module hack_mem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,

  // CPU data side
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              cpu_stall,

  // DMA engine
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter limit held at the counter's own width so comparisons need no casts.
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Number of consecutive cycles the DMA has been refused; saturates at LIMIT.
  logic [7:0] starve_cnt;
  logic       force_dma;

  // Once the DMA has waited LIMIT cycles it beats the CPU on the next contention.
  assign force_dma = (starve_cnt >= LIMIT);

  // Priority grant: DMA only when alone or starved, otherwise CPU; nothing while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (req1 && (!req0 || force_dma)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  // RAM command mux: the granted port owns the RAM; idle cycles drive a clean all-zero command.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // The CPU clock-enable drops whenever it asks but is not served, including forced DMA cycles.
  assign cpu_stall = req0 && !gnt0;

  // Both ports see the RAM output directly; rvalidN says whose data it is.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

  // Starvation counter: counts refused DMA cycles, restarts on a DMA grant or a withdrawn request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (gnt1 || !req1) begin
      starve_cnt <= '0;
    end else if (!force_dma) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Read-return strobes: one pulse the cycle after a granted read; reset drops any read in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end

endmodule
